// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access.
// Build option ARB_STARVE_GUARD_EN: force a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_dm
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;
    logic   grant_if;
    logic   grant_dm;
    logic   force_if;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [2:0] starve_cnt;

    assign force_if = (starve_cnt == STARVE_LIM) & if_req;

    // Counts data grants that made a waiting fetch wait longer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm && if_req && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    localparam int unused_starve_max = STARVE_MAX;

    assign force_if = 1'b0;
`endif

    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE) begin
            grant_dm = dm_req & ~force_if;
            grant_if = if_req & ~grant_dm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_dm) begin
                    state_nx = BUSY_DM;
                end else if (grant_if) begin
                    state_nx = BUSY_IF;
                end
            end
            BUSY_IF,
            BUSY_DM: begin
                if (mem_ack) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Port signals and completions are registered off the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_dm) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (grant_if) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_ack   <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                BUSY_DM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        dm_ack  <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_if = if_req & ~if_ack;
    assign stall_dm = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, timing and reset.
// Starvation expectations follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall_if;
    logic        stall_dm;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ack(if_ack),
        .if_rdata(if_rdata),
        .dm_req(dm_req),
        .dm_we(dm_we),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_ack(dm_ack),
        .dm_rdata(dm_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if),
        .stall_dm(stall_dm)
    );

    int n_checks = 0;
    int n_fails = 0;

    bit          resp_en = 1'b1;
    int          lat = 2;
    int          lat_cnt = 0;
    bit          prev_req = 1'b0;
    logic [31:0] held_addr = '0;
    logic        held_we = 1'b0;
    logic [31:0] held_wd = '0;
    logic [32:0] g_q[$];
    logic [31:0] gw_q[$];
    int          gc_q[$];
    int          cyc = 0;
    int          if_acks = 0;
    int          dm_acks = 0;
    int          if_ack_cyc = 0;
    bit          if_hold = 1'b0;
    bit          dm_hold = 1'b0;
    logic [9:0]  pat;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        g_q.delete();
        gw_q.delete();
        gc_q.delete();
        if_acks = 0;
        dm_acks = 0;
    endtask

    // One clock: memory model, grant log, requester drop on ack.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_ack) begin
            mem_ack = 1'b0;
            lat_cnt = 0;
        end else if (mem_req && resp_en) begin
            lat_cnt++;
            if (lat_cnt >= lat) mem_ack = 1'b1;
        end
        if (mem_req && prev_req) begin
            check("hold_addr", 64'(mem_addr), 64'(held_addr));
            check("hold_we_wd", 64'({mem_we, mem_wdata}),
                  64'({held_we, held_wd}));
        end
        if (mem_req && !prev_req) begin
            g_q.push_back({mem_we, mem_addr});
            gw_q.push_back(mem_wdata);
            gc_q.push_back(cyc);
            held_addr = mem_addr;
            held_we   = mem_we;
            held_wd   = mem_wdata;
        end
        prev_req = mem_req;
        if (if_ack) begin
            if_acks++;
            if_ack_cyc = cyc;
        end
        if (dm_ack) dm_acks++;
        if (if_ack && !if_hold) if_req = 1'b0;
        if (dm_ack && !dm_hold) dm_req = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (if_req || dm_req || mem_req); i++) step();
        check(tag, 64'({if_req, dm_req, mem_req}), 64'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_acks", 64'({if_ack, dm_ack}), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rdata", 64'({if_rdata, dm_rdata}), 64'd0);
        reset = 1'b0;
        step();

        // Fetch-only read
        clear_log();
        mem_rdata = 32'h8C01_0004;
        if_addr = 32'h40;
        if_req = 1'b1;
        #1;
        check("if_stall_wait", 64'(stall_if), 64'd1);
        drain("if_done");
        check("if_grants", 64'(g_q.size()), 64'd1);
        check("if_grant", 64'(g_q[0]), 64'({1'b0, 32'h40}));
        check("if_lat", 64'(if_ack_cyc - gc_q[0]), 64'd2);
        check("if_acks", 64'(if_acks), 64'd1);
        check("if_rdata", 64'(if_rdata), 64'h8C01_0004);
        check("if_stall_end", 64'(stall_if), 64'd0);

        // Data write
        clear_log();
        dm_we = 1'b1;
        dm_addr = 32'h100;
        dm_wdata = 32'hDEAD_BEEF;
        dm_req = 1'b1;
        drain("dmw_done");
        check("dmw_grants", 64'(g_q.size()), 64'd1);
        check("dmw_grant", 64'(g_q[0]), 64'({1'b1, 32'h100}));
        check("dmw_wdata", 64'(gw_q[0]), 64'hDEAD_BEEF);
        check("dmw_acks", 64'({if_acks, dm_acks}), 64'({32'd0, 32'd1}));
        check("dmw_rdata_keep", 64'(dm_rdata), 64'd0);

        // Simultaneous requests
        clear_log();
        mem_rdata = 32'h1234_5678;
        dm_we = 1'b0;
        dm_addr = 32'h104;
        if_addr = 32'h44;
        dm_req = 1'b1;
        if_req = 1'b1;
        #1;
        check("both_stall", 64'({stall_if, stall_dm}), 64'b11);
        drain("both_done");
        check("both_grants", 64'(g_q.size()), 64'd2);
        check("both_first", 64'(g_q[0]), 64'({1'b0, 32'h104}));
        check("both_second", 64'(g_q[1]), 64'({1'b0, 32'h44}));
        check("both_gap", 64'(gc_q[1] - gc_q[0]), 64'd4);
        check("both_dm_rdata", 64'(dm_rdata), 64'h1234_5678);
        check("both_if_rdata", 64'(if_rdata), 64'h1234_5678);
        check("both_acks", 64'({if_acks, dm_acks}), 64'({32'd1, 32'd1}));

        // Both requests held continuously
        clear_log();
        if_hold = 1'b1;
        dm_hold = 1'b1;
        if_addr = 32'h48;
        dm_addr = 32'h108;
        if_req = 1'b1;
        dm_req = 1'b1;
        for (int i = 0; i < 100 && g_q.size() < 10; i++) step();
        check("starve_n", 64'(g_q.size() >= 10), 64'd1);
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < g_q.size()) pat[i] = (g_q[i][31:0] == 32'h48);
        end
`ifdef ARB_STARVE_GUARD_EN
        check("starve_pattern", 64'(pat), 64'h210);
`else
        check("starve_pattern", 64'(pat), 64'h000);
`endif
        if_hold = 1'b0;
        dm_hold = 1'b0;
        drain("starve_drain");

        // Reset during BUSY_DM
        clear_log();
        resp_en = 1'b0;
        dm_we = 1'b1;
        dm_addr = 32'h10C;
        dm_wdata = 32'h0000_55AA;
        dm_req = 1'b1;
        step();
        check("rb_granted", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h10C}));
        step();
        #2;
        reset = 1'b1;
        #1;
        check("rb_req_drop", 64'({mem_req, mem_we}), 64'd0);
        check("rb_addr_clr", 64'(mem_addr), 64'd0);
        check("rb_no_ack", 64'(dm_ack), 64'd0);
        dm_req = 1'b0;
        lat_cnt = 0;
        step();
        reset = 1'b0;
        resp_en = 1'b1;
        if_addr = 32'h4C;
        if_req = 1'b1;
        step();
        check("rb_post_grant", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h4C}));
        drain("rb_drain");
        check("rb_acks", 64'({if_acks, dm_acks}), 64'({32'd1, 32'd0}));

        // Stray mem_ack while idle
        clear_log();
        resp_en = 1'b0;
        mem_ack = 1'b1;
        step();
        check("stray_outs", 64'({mem_req, if_ack, dm_ack}), 64'd0);
        step();
        check("stray_acks", 64'(if_acks + dm_acks), 64'd0);
        resp_en = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        dm_we = 1'b0;
        dm_addr = 32'h110;
        dm_req = 1'b1;
        step();
        check("stray_grant", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h110}));
        drain("stray_drain");
        check("stray_rdata", 64'(dm_rdata), 64'hCAFE_F00D);
        check("stray_dm_acks", 64'(dm_acks), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
